sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
// - Sequences base RAM (32-bit async SRAM, 20-bit word address) for two CPU requesters.
// - Requesters: instruction fetch (read-only) and data memory (read/write, byte enables).
// - Generates properly timed CE/OE/WE/BE strobes with registered outputs.
// - Returns one-cycle acks and a pipeline stall.
// - Sits between openmips and the top-level tristate; thinpad_top keeps the inout drive.
// PARAMETERS
// - RD_WAIT  1  extra cycles the read strobe is held before data is sampled (0..7)
// - WR_WAIT  1  extra cycles WE_n is held low beyond the first (0..7)
// PORTS
// - clk          in   1   system clock, single domain
// - rst_n        in   1   synchronous reset, active low
// - if_req       in   1   fetch request; held until if_ack
// - if_addr      in   32  fetch byte address
// - if_rdata     out  32  fetch data; valid while if_ack=1
// - if_ack       out  1   one-cycle completion pulse
// - mem_req      in   1   data request; held until mem_ack
// - mem_we       in   1   1=write, 0=read
// - mem_addr     in   32  data byte address
// - mem_sel      in   4   byte enables, active high
// - mem_wdata    in   32  write data
// - mem_rdata    out  32  read data; valid while mem_ack=1
// - mem_ack      out  1   one-cycle completion pulse
// - stall_o      out  1   (if_req&~if_ack)|(mem_req&~mem_ack), combinational
// - sram_addr    out  20  word address = latched addr[21:2]
// - sram_wdata   out  32  write data to tristate
// - sram_data_oe out  1   1 = top drives sram_wdata onto the bus
// - sram_rdata   in   32  bus read value
// - sram_ce_n / sram_oe_n / sram_we_n  out 1 each;  sram_be_n out 4
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge):
//   - State goes to IDLE.
//   - ce_n=oe_n=we_n=1, be_n=4'hF, data_oe=0.
//   - Acks=0, rdata regs=0, sram_addr=0.
//   - Any in-flight access is aborted with no ack.
// - FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK. All strobe outputs are registered.
// - IDLE: strobes inactive. Requests are sampled here only.
//   - mem_req has fixed priority over if_req.
//   - On grant, latch grantee, addr, sel, wdata, we; load cnt.
//   - Go to WR_SETUP if mem_we, else RD.
// - RD: ce_n=0, oe_n=0, we_n=1, be_n=0000 (full word; CPU extracts bytes).
//   - Stay RD_WAIT+1 cycles.
//   - On the last cycle, capture sram_rdata into the grantee's rdata reg; go to ACK.
// - WR_SETUP (1 cycle): ce_n=0, oe_n=1, we_n=1, be_n=~sel, data_oe=1.
// - WR_PULSE (WR_WAIT+1 cycles): as WR_SETUP but we_n=0.
// - WR_HOLD (1 cycle): we_n=1, data_oe=1, addr/be stable; then ACK.
// - ACK (1 cycle): strobes inactive, ack of grantee=1, then IDLE.
//   - Back-to-back grants are therefore separated by >=1 idle cycle.
// - Latency (IDLE sample at cycle N, request already high):
//   - read ack at N+2+RD_WAIT;
//   - write ack at N+4+WR_WAIT.
// - Invariants:
//   - data_oe=1 never coincides with oe_n=0.
//   - we_n falls only after addr/be/data have been stable >=1 cycle.
//   - Addr changes only in IDLE.
// - Boundary cases:
//   - Both requesting in IDLE: mem wins; if_req stays pending; if is served next grant.
//   - Request dropped mid-access: access completes and ack still pulses; requester ignores it.
//   - mem_sel=0000 write: full sequence runs, be_n=1111, ack issued.
//   - Address bits [31:22] and [1:0] are ignored.
//   - rst_n low in any state: next edge is IDLE with reset outputs; no partial WE pulse is extended.
// STRUCTURE
// - sram_defines.vh holds:
//   - state encodings (3-bit localparams);
//   - SRAM word-address width (20);
//   - grantee encoding (GNT_IF=0, GNT_MEM=1).
// - Single module, no sub-module.
// - Wait counter is a 3-bit down-counter inside the FSM.
// - Tristate resolution stays at top level.
// TESTING
// - Bench uses an SRAM model checking setup/hold vs strobes.
// - 1. Read: if_req, if_addr=32'h0000_0010, model word4=32'hDEADBEEF (RD_WAIT=1)
//   -> ce_n/oe_n low 2 cycles, sram_addr=4.
//   -> if_ack at N+3, if_rdata=32'hDEADBEEF.
// - 2. Write: mem_we=1, addr=32'h0000_0104, sel=4'b0011, wdata=32'h1234_5678 (WR_WAIT=1)
//   -> be_n=1100, we_n low 2 cycles.
//   -> model word 0x41 low half=16'h5678; mem_ack at N+5.
// - 3. Contention: if_req and mem_req (read) rise same cycle
//   -> mem_ack first, then if_ack.
//   -> stall_o high until if_ack; no bus overlap.
// - 4. Reset mid-write: rst_n=0 during WR_PULSE
//   -> next edge we_n=1, ce_n=1, data_oe=0, no ack.
//   -> a fresh read after reset returns correct data.
// - 5. Back-to-back fetches at addr 0,4,8 held continuously
//   -> three acks with one idle cycle between accesses; data matches model.
// - 6. Assertion sweep over random traffic:
//   -> never data_oe&~oe_n;
//   -> acks are one-cycle and mutually exclusive.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the base-RAM arbiter: FSM states, grantee
// encoding, latched request payload and the registered strobe bundle.
package sram_arbiter_pkg;

  localparam int unsigned SRAM_AW = 20;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_ACK      = 3'd5
  } state_t;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_t;

  // Access captured at grant time; held unchanged until the next grant
  typedef struct packed {
    logic               we;
    logic [SRAM_AW-1:0] addr;
    logic [BE_W-1:0]    sel;
    logic [DATA_W-1:0]  wdata;
  } sram_req_t;

  typedef struct packed {
    logic            ce_n;
    logic            oe_n;
    logic            we_n;
    logic [BE_W-1:0] be_n;
    logic            data_oe;
  } sram_strb_t;

  localparam sram_strb_t STRB_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                       be_n: 4'hF, data_oe: 1'b0};

endpackage

// File: rtl/sram_arbiter.sv
// Base-RAM sequencer: arbitrates instruction fetch and data port onto one
// asynchronous SRAM, producing registered CE/OE/WE/BE strobes and one-cycle acks.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_req,
  input  logic [DATA_W-1:0]  if_addr,
  output logic [DATA_W-1:0]  if_rdata,
  output logic               if_ack,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [DATA_W-1:0]  mem_addr,
  input  logic [BE_W-1:0]    mem_sel,
  input  logic [DATA_W-1:0]  mem_wdata,
  output logic [DATA_W-1:0]  mem_rdata,
  output logic               mem_ack,
  output logic               stall_o,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  output logic               sram_data_oe,
  input  logic [DATA_W-1:0]  sram_rdata,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [BE_W-1:0]    sram_be_n
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  gnt_t              gnt, gnt_nxt;
  sram_req_t         req_q, req_nxt;
  sram_strb_t        strb_q, strb_nxt;
  logic              if_ack_nxt, mem_ack_nxt;
  logic              rd_done;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic              if_ack_q, mem_ack_q;

  // Byte-offset and above-window address bits never reach the SRAM
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[DATA_W-1:SRAM_AW+2], if_addr[1:0],
                              mem_addr[DATA_W-1:SRAM_AW+2], mem_addr[1:0]};

  assign rd_done = (state == ST_RD) && (cnt == '0);

  // Next-state, latched request and next strobe values
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    gnt_nxt     = gnt;
    req_nxt     = req_q;
    strb_nxt    = STRB_IDLE;
    if_ack_nxt  = 1'b0;
    mem_ack_nxt = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (mem_req) begin
          gnt_nxt = GNT_MEM;
          req_nxt = '{we: mem_we, addr: mem_addr[SRAM_AW+1:2],
                      sel: mem_sel, wdata: mem_wdata};
        end else if (if_req) begin
          gnt_nxt = GNT_IF;
          req_nxt = '{we: 1'b0, addr: if_addr[SRAM_AW+1:2],
                      sel: {BE_W{1'b1}}, wdata: '0};
        end
        if (mem_req || if_req) begin
          state_nxt = req_nxt.we ? ST_WR_SETUP : ST_RD;
          cnt_nxt   = CNT_W'(RD_WAIT);
        end
      end
      ST_RD: begin
        if (cnt == '0) state_nxt = ST_ACK;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_WR_SETUP: begin
        state_nxt = ST_WR_PULSE;
        cnt_nxt   = CNT_W'(WR_WAIT);
      end
      ST_WR_PULSE: begin
        if (cnt == '0) state_nxt = ST_WR_HOLD;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_WR_HOLD: state_nxt = ST_ACK;
      ST_ACK:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase

    // Strobes are registered, so they are derived from the state being entered
    case (state_nxt)
      ST_RD:
        strb_nxt = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1,
                     be_n: '0, data_oe: 1'b0};
      ST_WR_SETUP, ST_WR_HOLD:
        strb_nxt = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1,
                     be_n: ~req_nxt.sel, data_oe: 1'b1};
      ST_WR_PULSE:
        strb_nxt = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0,
                     be_n: ~req_nxt.sel, data_oe: 1'b1};
      ST_ACK: begin
        if_ack_nxt  = (gnt_nxt == GNT_IF);
        mem_ack_nxt = (gnt_nxt == GNT_MEM);
      end
      default: ;
    endcase
  end

  // State, latched access and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      gnt         <= GNT_IF;
      req_q       <= '0;
      strb_q      <= STRB_IDLE;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      req_q     <= req_nxt;
      strb_q    <= strb_nxt;
      if_ack_q  <= if_ack_nxt;
      mem_ack_q <= mem_ack_nxt;
      if (rd_done) begin
        if (gnt == GNT_IF) if_rdata_q  <= sram_rdata;
        else               mem_rdata_q <= sram_rdata;
      end
    end
  end

  assign if_rdata     = if_rdata_q;
  assign mem_rdata    = mem_rdata_q;
  assign if_ack       = if_ack_q;
  assign mem_ack      = mem_ack_q;
  assign sram_addr    = req_q.addr;
  assign sram_wdata   = req_q.wdata;
  assign sram_ce_n    = strb_q.ce_n;
  assign sram_oe_n    = strb_q.oe_n;
  assign sram_we_n    = strb_q.we_n;
  assign sram_be_n    = strb_q.be_n;
  assign sram_data_oe = strb_q.data_oe;

  assign stall_o = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async-SRAM model and
// per-cycle bus invariant checks.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel;
  logic        stall_o;
  logic [19:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  always #5 clk = ~clk;

  sram_arbiter #(.RD_WAIT(1), .WR_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_o(stall_o), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_data_oe(sram_data_oe), .sram_rdata(sram_rdata),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n)
  );

  logic [31:0] mem [0:1023];
  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 32'h0;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  logic        prev_we_n = 1'b1, prev_ce_n = 1'b1, prev_doe = 1'b0;
  logic        prev_if_ack = 1'b0, prev_mem_ack = 1'b0;
  logic [19:0] prev_addr = '0;
  logic [3:0]  prev_be = 4'hF;
  logic [31:0] prev_wdata = '0;

  typedef struct {
    bit          use_mem;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [19:0] exp_waddr;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, sample after the edge, update the SRAM model, check invariants
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!sram_ce_n && !sram_we_n && sram_data_oe)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) mem[sram_addr[9:0]][8*b +: 8] = sram_wdata[8*b +: 8];
    chk("oe_overlap", {31'b0, sram_data_oe & ~sram_oe_n}, 32'd0);
    chk("ack_excl", {31'b0, if_ack & mem_ack}, 32'd0);
    chk("ack_pulse", {31'b0, (prev_if_ack & if_ack) | (prev_mem_ack & mem_ack)}, 32'd0);
    chk("stall", {31'b0, stall_o}, {31'b0, (if_req & ~if_ack) | (mem_req & ~mem_ack)});
    if (prev_we_n && !sram_we_n) begin
      chk("we_setup_addr", {12'b0, sram_addr}, {12'b0, prev_addr});
      chk("we_setup_be", {28'b0, sram_be_n}, {28'b0, prev_be});
      chk("we_setup_data", sram_wdata, prev_wdata);
      chk("we_setup_strb", {30'b0, prev_ce_n, prev_doe}, 32'd1);
    end
    prev_we_n = sram_we_n;  prev_ce_n = sram_ce_n;  prev_doe = sram_data_oe;
    prev_addr = sram_addr;  prev_be = sram_be_n;    prev_wdata = sram_wdata;
    prev_if_ack = if_ack;   prev_mem_ack = mem_ack;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat = 0, rd_cyc = 0, we_cyc = 0;
    bit got = 0;
    logic [3:0]  be_seen = 4'hF;
    logic [19:0] addr_seen = '0;
    logic [31:0] rdata = '0;
    if (v.use_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_sel = v.sel; mem_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      lat++;
      if (!sram_ce_n && !sram_oe_n) rd_cyc++;
      if (!sram_we_n) begin we_cyc++; be_seen = sram_be_n; end
      if (!sram_ce_n) addr_seen = sram_addr;
      if (v.use_mem ? mem_ack : if_ack) begin
        got = 1;
        rdata = v.use_mem ? mem_rdata : if_rdata;
      end
    end
    mem_req = 1'b0; if_req = 1'b0;
    chk($sformatf("vec%0d_ack_seen", idx), {31'b0, got}, 32'd1);
    chk($sformatf("vec%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("vec%0d_waddr", idx), {12'b0, addr_seen}, {12'b0, v.exp_waddr});
    if (v.we) begin
      chk($sformatf("vec%0d_we_cycles", idx), we_cyc, 2);
      chk($sformatf("vec%0d_be_n", idx), {28'b0, be_seen}, {28'b0, ~v.sel});
      chk($sformatf("vec%0d_no_read", idx), rd_cyc, 0);
    end else begin
      chk($sformatf("vec%0d_rd_cycles", idx), rd_cyc, 2);
      chk($sformatf("vec%0d_rdata", idx), rdata, v.exp_rdata);
    end
    tick();
  endtask

  initial begin
    int t_mem, t_if, acks;
    int ack_cyc [3];
    bit got;
    logic [31:0] exp_b2b [3];
    logic [9:0]  if_word, mem_word;
    bit          mem_is_wr;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[1] = 32'h1111_1111; mem[2] = 32'h2222_2222; mem[3] = 32'h3333_3333;
    mem[4] = 32'hDEAD_BEEF; mem[10'h41] = 32'hAAAA_AAAA;

    //          mem we addr          sel      wdata          exp_rdata     lat waddr
    vecs[0]  = '{0, 0, 32'h0000_0010, 4'hF,    32'h0,         32'hDEAD_BEEF, 3, 20'h4};
    vecs[1]  = '{1, 1, 32'h0000_0104, 4'b0011, 32'h1234_5678, 32'h0,         5, 20'h41};
    vecs[2]  = '{1, 0, 32'h0000_0104, 4'hF,    32'h0,         32'hAAAA_5678, 3, 20'h41};
    vecs[3]  = '{1, 1, 32'h0000_0104, 4'b1100, 32'h9ABC_DEF0, 32'h0,         5, 20'h41};
    vecs[4]  = '{1, 0, 32'hFFC0_0106, 4'hF,    32'h0,         32'h9ABC_5678, 3, 20'h41};
    vecs[5]  = '{1, 1, 32'h0000_0008, 4'b0000, 32'hFFFF_FFFF, 32'h0,         5, 20'h2};
    vecs[6]  = '{0, 0, 32'h0000_0008, 4'hF,    32'h0,         32'h2222_2222, 3, 20'h2};
    vecs[7]  = '{1, 1, 32'h0000_000C, 4'b1111, 32'hCAFE_F00D, 32'h0,         5, 20'h3};
    vecs[8]  = '{0, 0, 32'h0000_000C, 4'hF,    32'h0,         32'hCAFE_F00D, 3, 20'h3};
    vecs[9]  = '{1, 1, 32'h0000_0000, 4'b0101, 32'h1122_3344, 32'h0,         5, 20'h0};
    vecs[10] = '{1, 0, 32'h0000_0003, 4'hF,    32'h0,         32'h0022_0044, 3, 20'h0};

    rst_n = 1'b0; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
    mem_addr = 0; mem_sel = 0; mem_wdata = 0;
    tick(); tick();
    chk("rst_strobes", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'hE);
    chk("rst_be_n", {28'b0, sram_be_n}, 32'hF);
    chk("rst_acks", {30'b0, if_ack, mem_ack}, 32'd0);
    chk("rst_addr", {12'b0, sram_addr}, 32'd0);
    chk("rst_rdata", if_rdata | mem_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);
    chk("model_word41", mem[10'h41], 32'h9ABC_5678);
    chk("model_word2_untouched", mem[2], 32'h2222_2222);

    // Contention: mem wins, fetch served on the following grant
    if_req = 1; if_addr = 32'h10; mem_req = 1; mem_we = 0; mem_addr = 32'h8;
    t_mem = -1; t_if = -1;
    for (int i = 1; i <= 30 && t_if < 0; i++) begin
      tick();
      if (mem_ack) begin
        t_mem = i; mem_req = 0;
        chk("cont_mem_rdata", mem_rdata, 32'h2222_2222);
      end
      if (if_ack) begin
        t_if = i; if_req = 0;
        chk("cont_if_rdata", if_rdata, 32'hDEAD_BEEF);
      end
    end
    if_req = 0; mem_req = 0;
    chk("cont_mem_ack_cycle", t_mem, 3);
    chk("cont_if_ack_cycle", t_if, 7);
    tick();

    // Reset during the write pulse aborts the access
    mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_sel = 4'hF; mem_wdata = 32'h5555_5555;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (!sram_we_n) got = 1;
    end
    chk("rstw_reached_pulse", {31'b0, got}, 32'd1);
    rst_n = 0; mem_req = 0;
    tick();
    chk("rstw_strobes", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'hE);
    chk("rstw_be_n", {28'b0, sram_be_n}, 32'hF);
    chk("rstw_addr", {12'b0, sram_addr}, 32'd0);
    chk("rstw_acks", {30'b0, if_ack, mem_ack}, 32'd0);
    rst_n = 1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acks += int'(if_ack) + int'(mem_ack);
    end
    chk("rstw_no_ack", acks, 0);
    run_vec(vecs[0], 100);

    // Back-to-back fetches with the request held high
    exp_b2b[0] = 32'h0022_0044; exp_b2b[1] = 32'h1111_1111; exp_b2b[2] = 32'h2222_2222;
    if_req = 1; if_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      got = 0; ack_cyc[k] = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        tick();
        if (if_ack) begin got = 1; ack_cyc[k] = cyc; end
      end
      chk($sformatf("b2b%0d_ack_seen", k), {31'b0, got}, 32'd1);
      chk($sformatf("b2b%0d_rdata", k), if_rdata, exp_b2b[k]);
      if_addr = 32'((k + 1) * 4);
    end
    if_req = 0;
    chk("b2b_gap01", ack_cyc[1] - ack_cyc[0], 4);
    chk("b2b_gap12", ack_cyc[2] - ack_cyc[1], 4);
    tick();

    // Random traffic; invariants are checked inside tick()
    acks = 0; if_word = '0; mem_word = '0; mem_is_wr = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (if_ack && if_req) begin
        acks++;
        chk("rand_if_rdata", if_rdata, mem[if_word]);
        if_req = 0;
      end
      if (mem_ack && mem_req) begin
        acks++;
        if (!mem_is_wr) chk("rand_mem_rdata", mem_rdata, mem[mem_word]);
        mem_req = 0;
      end
      if (!if_req && ($urandom_range(3) == 0)) begin
        if_word = 10'($urandom_range(15));
        if_addr = {20'b0, if_word, 2'b00};
        if_req  = 1;
      end
      if (!mem_req && ($urandom_range(3) == 0)) begin
        mem_word  = 10'h100 + 10'($urandom_range(15));
        mem_is_wr = 1'($urandom_range(1));
        mem_we    = mem_is_wr;
        mem_addr  = {20'b0, mem_word, 2'($urandom_range(3))};
        mem_sel   = 4'($urandom_range(15));
        mem_wdata = $urandom;
        mem_req   = 1;
      end
    end
    if_req = 0; mem_req = 0;
    chk("rand_acks_seen", {31'b0, acks > 10}, 32'd1);
    for (int i = 0; i < 10; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
